player_motion_controller: RTL
=============================

PLAYER_MOTION_CONTROLLER -- requirements
Module: player_motion_controller

Interface
REQ-001 SHALL have parameter X_MIN, default 10'd0, left clamp for player_x.
REQ-002 SHALL have parameter X_MAX, default 10'd600, right clamp for player_x.
REQ-003 SHALL have parameter X_START, default 10'd100, player_x after reset.
REQ-004 SHALL have parameter Y_GROUND, default 10'd400, ground row for player_y (screen y grows downward).
REQ-005 SHALL have parameter STEP_X, default 10'd2, horizontal pixels per frame while moving.
REQ-006 SHALL have parameter JUMP_V0, default 6'd12, initial upward speed in pixels/frame.
REQ-007 SHALL have parameter GRAVITY, default 6'd1, speed change per frame.
REQ-008 SHALL have parameter VMAX, default 6'd12, terminal fall speed.
REQ-009 SHALL have port frame_clk  input  1  sole clock, one rising edge per video frame.
REQ-010 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on frame_clk rising edge.
REQ-011 SHALL have port keycode  input  8  current key: 8'd07 right, 8'd04 left, 8'd26 jump, other values idle.
REQ-012 SHALL have port direction  output  1  facing: 1 right, 0 left; drives the animation block.
REQ-013 SHALL have port jumping  output  1  high while airborne; drives the animation block.
REQ-014 SHALL have port player_x  output  10  player left edge, unsigned pixels.
REQ-015 SHALL have port player_y  output  10  player top/ground row, unsigned pixels.

Function
REQ-016 SHALL implement a registered FSM with states GROUND, RISE, FALL; all outputs come from registers, no combinational path keycode->outputs.
REQ-017 SHALL update all state once per frame_clk rising edge; one edge = one frame.
REQ-018 SHALL detect jump as keycode==8'd26 this frame and !=8'd26 the previous frame (registered prev-key flag); holding the key SHALL NOT re-trigger.
REQ-019 GROUND: on jump edge -> RISE, vy<=JUMP_V0, player_y unchanged that edge; otherwise stay, vy=0.
REQ-020 RISE: player_y<=player_y-vy; if vy<=GRAVITY -> FALL with vy<=0, else vy<=vy-GRAVITY.
REQ-021 FALL: vn=min(vy+GRAVITY,VMAX); if player_y+vn>=Y_GROUND -> player_y<=Y_GROUND, vy<=0, GROUND; else player_y<=player_y+vn, vy<=vn.
REQ-022 SHALL ignore jump edges in RISE and FALL (no double jump); prev-key flag still tracks.
REQ-023 jumping SHALL be 1 exactly when state is RISE or FALL.
REQ-024 Horizontal, all states (air control): keycode 8'd07 -> player_x<=min(player_x+STEP_X,X_MAX), direction<=1; 8'd04 -> player_x<=max(player_x-STEP_X,X_MIN), direction<=0; else hold both.
REQ-025 Clamp arithmetic SHALL use 11-bit intermediates so player_x+STEP_X and player_x-STEP_X never wrap (player_x<STEP_X going left -> X_MIN).
REQ-026 player_y SHALL never go below 0 in RISE: if vy>player_y, player_y<=0 and -> FALL, vy<=0.
REQ-027 vy SHALL be 6-bit unsigned magnitude; sign implied by state.

Reset
REQ-028 Reset high at a rising edge SHALL set state GROUND, player_x=X_START, player_y=Y_GROUND, vy=0, direction=1, jumping=0, prev-key flag=0, overriding all other inputs.
REQ-029 Reset mid-jump SHALL return to GROUND at Y_GROUND on that edge; no landing sequence.
REQ-030 A jump key held through reset release SHALL trigger a jump (prev flag cleared) at the first edge with Reset low.

Verification
REQ-031 Reset, keycode=0 for 5 frames -> x=100, y=400, direction=1, jumping=0 throughout.
REQ-032 keycode=26 one frame after ground idle -> jumping=1 for exactly 24 frames; y minimum 322 after 12 frames; y=400 and jumping=0 on frame 25; vy=0.
REQ-033 keycode=26 held 40 frames -> exactly one jump (24 airborne frames), then GROUND with y=400.
REQ-034 keycode=04 held 60 frames from x=100 -> x decreases by 2/frame, reaches 0 at frame 50, stays 0; direction=0.
REQ-035 jump pressed, then keycode=07 for 10 frames mid-air -> x=120, direction=1, trajectory unchanged, lands at y=400.
REQ-036 Reset asserted at frame 6 of a jump -> next frame y=400, jumping=0, x=100, direction=1.

Source files
------------

// File: rtl/player_motion_controller.sv
// Per-frame player motion: horizontal walk with clamping plus a three-state
// jump/fall FSM. Every output is taken from registers that update once per frame.
module player_motion_controller #(
  parameter logic [9:0] X_MIN    = 10'd0,
  parameter logic [9:0] X_MAX    = 10'd600,
  parameter logic [9:0] X_START  = 10'd100,
  parameter logic [9:0] Y_GROUND = 10'd400,
  parameter logic [9:0] STEP_X   = 10'd2,
  parameter logic [5:0] JUMP_V0  = 6'd12,
  parameter logic [5:0] GRAVITY  = 6'd1,
  parameter logic [5:0] VMAX     = 6'd12
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       direction,
  output logic       jumping,
  output logic [9:0] player_x,
  output logic [9:0] player_y
);

  localparam logic [7:0] KEY_RIGHT = 8'd7;
  localparam logic [7:0] KEY_LEFT  = 8'd4;
  localparam logic [7:0] KEY_JUMP  = 8'd26;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [5:0]  vy, vy_next;
  logic [9:0]  y_next;
  logic [9:0]  x_next;
  logic        dir_next;
  logic        prev_jump;
  logic        jump_key;
  logic        jump_edge;

  logic [6:0]  v_sum;
  logic [5:0]  vn;
  logic [10:0] y_sum;
  logic [10:0] x_plus;
  logic [10:0] x_floor;

  assign jump_key  = (keycode == KEY_JUMP);
  assign jump_edge = jump_key && !prev_jump;
  assign jumping   = (state != GROUND);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state     <= GROUND;
      vy        <= '0;
      player_y  <= Y_GROUND;
      player_x  <= X_START;
      direction <= 1'b1;
      prev_jump <= 1'b0;
    end else begin
      state     <= state_next;
      vy        <= vy_next;
      player_y  <= y_next;
      player_x  <= x_next;
      direction <= dir_next;
      prev_jump <= jump_key;
    end
  end

  // Falling speed candidate, saturated at terminal velocity.
  always_comb begin
    v_sum = {1'b0, vy} + {1'b0, GRAVITY};
    vn    = (v_sum > {1'b0, VMAX}) ? VMAX : v_sum[5:0];
    y_sum = {1'b0, player_y} + {5'b0, vn};
  end

  always_comb begin
    state_next = state;
    vy_next    = vy;
    y_next     = player_y;
    unique case (state)
      GROUND: begin
        vy_next = '0;
        if (jump_edge) begin
          state_next = RISE;
          vy_next    = JUMP_V0;
        end
      end
      RISE: begin
        if ({4'b0, vy} > player_y) begin
          y_next     = '0;
          vy_next    = '0;
          state_next = FALL;
        end else begin
          y_next = player_y - {4'b0, vy};
          if (vy <= GRAVITY) begin
            vy_next    = '0;
            state_next = FALL;
          end else begin
            vy_next = vy - GRAVITY;
          end
        end
      end
      FALL: begin
        if (y_sum >= {1'b0, Y_GROUND}) begin
          y_next     = Y_GROUND;
          vy_next    = '0;
          state_next = GROUND;
        end else begin
          y_next  = y_sum[9:0];
          vy_next = vn;
        end
      end
      default: begin
        state_next = GROUND;
        vy_next    = '0;
        y_next     = Y_GROUND;
      end
    endcase
  end

  // Widened sums keep the clamp compares free of wraparound at either edge.
  always_comb begin
    x_plus   = {1'b0, player_x} + {1'b0, STEP_X};
    x_floor  = {1'b0, X_MIN} + {1'b0, STEP_X};
    x_next   = player_x;
    dir_next = direction;
    if (keycode == KEY_RIGHT) begin
      x_next   = (x_plus > {1'b0, X_MAX}) ? X_MAX : x_plus[9:0];
      dir_next = 1'b1;
    end else if (keycode == KEY_LEFT) begin
      x_next   = ({1'b0, player_x} < x_floor) ? X_MIN : (player_x - STEP_X);
      dir_next = 1'b0;
    end
  end

endmodule
